// File: rtl/softmax_pkg.sv
// Shared constants and state encoding for the softmax exponent-LUT sequencer.
package softmax_pkg;

   localparam int DEF_N_CLASSES = 8;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_LUT_AW    = 8;
   localparam int DEF_SHIFT     = 6;
   localparam int DEF_CLS_W     = $clog2(DEF_N_CLASSES);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LOOKUP,
      WAIT,
      PRESENT
   } state_t;

endpackage

// File: rtl/softmax_idx_calc.sv
// Combinational LUT index: (max - x) >> SHIFT, saturated to the LUT address range.
module softmax_idx_calc
   import softmax_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LUT_AW = DEF_LUT_AW,
   parameter int SHIFT  = DEF_SHIFT
) (
   input  logic signed [DATA_W-1:0] max_val,
   input  logic signed [DATA_W-1:0] x_val,
   output logic        [LUT_AW-1:0] addr
);

   localparam logic [DATA_W:0] ADDR_MAX = (DATA_W+1)'((1 << LUT_AW) - 1);

   logic [DATA_W:0] diff;
   logic [DATA_W:0] shifted;

   // One extra bit so the full signed span (max - min) stays non-negative.
   assign diff    = {max_val[DATA_W-1], max_val} - {x_val[DATA_W-1], x_val};
   assign shifted = diff >> SHIFT;
   assign addr    = (shifted > ADDR_MAX) ? '1 : shifted[LUT_AW-1:0];

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Buffers one frame of logits, tracks max/argmax, then sequences one exp-LUT read per class.
module softmax_seq_ctrl
   import softmax_pkg::*;
#(
   parameter int N_CLASSES = DEF_N_CLASSES,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int LUT_AW    = DEF_LUT_AW,
   parameter int SHIFT     = DEF_SHIFT,
   parameter int LUT_LAT   = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_last,
   output logic                         lut_rd_en,
   output logic [LUT_AW-1:0]            lut_addr,
   input  logic [DATA_W-1:0]            lut_rd_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [$clog2(N_CLASSES)-1:0] out_class,
   output logic                         out_last,
   output logic [$clog2(N_CLASSES)-1:0] argmax,
   output logic                         busy,
   output logic                         err_len
);

   localparam int            CW       = $clog2(N_CLASSES);
   localparam int            WW       = (LUT_LAT > 1) ? $clog2(LUT_LAT) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N_CLASSES - 1);

   state_t                   state;
   logic signed [DATA_W-1:0] frame_buf [N_CLASSES];
   logic signed [DATA_W-1:0] max_r, max_upd, max_sel, x_sel;
   logic [CW-1:0]            in_cnt, cls, next_cls;
   logic [WW-1:0]            wait_cnt;
   logic [LUT_AW-1:0]        idx;
   logic                     beat, gt;

   assign beat     = in_valid & in_ready;
   assign gt       = $signed(in_data) > max_r;
   assign max_upd  = gt ? $signed(in_data) : max_r;
   assign next_cls = (cls == LAST_IDX) ? '0 : cls + 1'b1;

   // The class-0 address is issued on the same edge as the final beat, so it must see that beat's max.
   assign max_sel = (state == LOAD) ? max_upd : max_r;
   assign x_sel   = (state == LOAD) ? frame_buf[0] : frame_buf[next_cls];

   softmax_idx_calc #(
      .DATA_W(DATA_W),
      .LUT_AW(LUT_AW),
      .SHIFT (SHIFT)
   ) u_idx_calc (
      .max_val(max_sel),
      .x_val  (x_sel),
      .addr   (idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CLASSES; i++) frame_buf[i] <= '0;
      end else if (beat) begin
         frame_buf[in_cnt] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         lut_rd_en <= 1'b0;
         lut_addr  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_class <= '0;
         out_last  <= 1'b0;
         argmax    <= '0;
         busy      <= 1'b0;
         err_len   <= 1'b0;
         max_r     <= '0;
         in_cnt    <= '0;
         cls       <= '0;
         wait_cnt  <= '0;
      end else begin
         err_len   <= 1'b0;
         lut_rd_en <= 1'b0;
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (beat) begin
                  max_r  <= $signed(in_data);
                  argmax <= '0;
                  // With at least two classes, in_last on beat 0 is always a short frame.
                  if (in_last) begin
                     err_len <= 1'b1;
                  end else begin
                     in_cnt <= CW'(1);
                     busy   <= 1'b1;
                     state  <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (beat) begin
                  if (gt) begin
                     max_r  <= max_upd;
                     argmax <= in_cnt;
                  end
                  if (in_cnt == LAST_IDX) begin
                     err_len   <= ~in_last;
                     in_cnt    <= '0;
                     cls       <= '0;
                     in_ready  <= 1'b0;
                     lut_rd_en <= 1'b1;
                     lut_addr  <= idx;
                     state     <= LOOKUP;
                  end else if (in_last) begin
                     err_len <= 1'b1;
                     in_cnt  <= '0;
                     busy    <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     in_cnt <= in_cnt + 1'b1;
                  end
               end
            end
            LOOKUP: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == WW'(LUT_LAT - 1)) begin
                  out_data  <= lut_rd_data;
                  out_class <= cls;
                  out_last  <= (cls == LAST_IDX);
                  out_valid <= 1'b1;
                  state     <= PRESENT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            PRESENT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     busy     <= 1'b0;
                     in_ready <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     cls       <= next_cls;
                     lut_rd_en <= 1'b1;
                     lut_addr  <= idx;
                     state     <= LOOKUP;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Scoreboard bench for softmax_seq_ctrl with a 1-cycle exp LUT model (7FFF >> addr[3:0]).
module tb_softmax_seq_ctrl;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  cls;
      logic        last;
      logic [2:0]  am;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        lut_rd_en;
   logic [7:0]  lut_addr;
   logic [15:0] lut_rd_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic [2:0]  out_class;
   logic        out_last;
   logic [2:0]  argmax;
   logic        busy;
   logic        err_len;

   beat_t      exp_q[$];
   logic [7:0] addr_q[$];
   int         n_cmp = 0, n_fail = 0;
   int         rd_cnt = 0, beat_cnt = 0, err_cnt = 0;
   int         frame_vals[8];
   bit         rand_ready = 1'b0, ready_level = 1'b1, stalled = 1'b0;
   beat_t      snap;

   softmax_seq_ctrl #(
      .N_CLASSES(8), .DATA_W(16), .LUT_AW(8), .SHIFT(6), .LUT_LAT(1)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .lut_rd_en(lut_rd_en), .lut_addr(lut_addr), .lut_rd_data(lut_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_class(out_class), .out_last(out_last), .argmax(argmax),
      .busy(busy), .err_len(err_len)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (lut_rd_en) lut_rd_data <= 16'h7FFF >> lut_addr[3:0];

   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 99) < 30) : ready_level;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Monitor: LUT reads and output handshakes are popped from the scoreboard as they appear.
   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (lut_rd_en) begin
            rd_cnt++;
            n_cmp++;
            if (addr_q.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL lut_read: got unexpected read addr %0d expected none", lut_addr);
            end else begin
               logic [7:0] ea;
               ea = addr_q.pop_front();
               if (lut_addr !== ea) begin
                  n_fail++;
                  $display("[TB] FAIL lut_addr: got %0d expected %0d", lut_addr, ea);
               end
            end
         end
         if (out_valid) begin
            if (stalled) begin
               n_cmp++;
               if ({out_data, out_class, out_last, argmax} !== snap) begin
                  n_fail++;
                  $display("[TB] FAIL stall_hold: got %h expected %h",
                           {out_data, out_class, out_last, argmax}, snap);
               end
            end
            if (out_ready) begin
               beat_cnt++;
               stalled = 1'b0;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("[TB] FAIL out_beat: got unexpected class %0d expected none", out_class);
               end else begin
                  beat_t e;
                  e = exp_q.pop_front();
                  if ({out_data, out_class, out_last, argmax} !== e) begin
                     n_fail++;
                     $display("[TB] FAIL out_beat: got data %h cls %0d last %0b am %0d expected data %h cls %0d last %0b am %0d",
                              out_data, out_class, out_last, argmax, e.data, e.cls, e.last, e.am);
                  end
               end
            end else begin
               stalled = 1'b1;
               snap    = {out_data, out_class, out_last, argmax};
            end
         end else if (stalled) begin
            n_cmp++;
            n_fail++;
            stalled = 1'b0;
            $display("[TB] FAIL stall_drop: got out_valid 0 expected 1");
         end
         if (err_len) err_cnt++;
      end
   end

   function automatic int ref_addr(input int mx, input int x);
      int d;
      d = (mx - x) / 64;
      return (d > 255) ? 255 : d;
   endfunction

   task automatic push_expected();
      int    mx, am, a;
      beat_t e;
      mx = frame_vals[0];
      am = 0;
      for (int k = 1; k < 8; k++) if (frame_vals[k] > mx) begin mx = frame_vals[k]; am = k; end
      for (int k = 0; k < 8; k++) begin
         a      = ref_addr(mx, frame_vals[k]);
         addr_q.push_back(8'(a));
         e.data = 16'h7FFF >> (a % 16);
         e.cls  = 3'(k);
         e.last = (k == 7);
         e.am   = 3'(am);
         exp_q.push_back(e);
      end
   endtask

   // last_pos is the beat carrying in_last; 8 means no in_last at all.
   task automatic send_frame(input int last_pos);
      int nb, g;
      nb = (last_pos < 7) ? last_pos + 1 : 8;
      if (last_pos >= 7) push_expected();
      @(posedge clk); #1;
      for (int k = 0; k < nb; k++) begin
         in_valid = 1'b1;
         in_data  = 16'(frame_vals[k]);
         in_last  = (k == last_pos);
         g = 0;
         @(negedge clk);
         while (!in_ready && g < 300) begin @(negedge clk); g++; end
         if (g >= 300) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL in_ready_timeout: got 0 expected 1 at beat %0d", k);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int g = 0; g < 3000; g++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && addr_q.size() == 0 && !busy) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({in_ready, lut_rd_en, out_valid, out_last, busy, err_len} !== 6'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                  {in_ready, lut_rd_en, out_valid, out_last, busy, err_len});
      end
      n_cmp++;
      if ({out_data, lut_addr, out_class, argmax} !== 30'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_data: got %h expected 0", {out_data, lut_addr, out_class, argmax});
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({in_ready, busy} !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL reset_release: got in_ready/busy %b expected 10", {in_ready, busy});
      end
   endtask

   task automatic test_ramp();
      bit ok;
      for (int k = 0; k < 8; k++) frame_vals[k] = 64 * k;
      send_frame(7);
      @(negedge clk);
      n_cmp++;
      if ({lut_rd_en, out_valid, busy} !== 3'b101) begin
         n_fail++;
         $display("[TB] FAIL latency_rd: got rd/ov/busy %b expected 101", {lut_rd_en, out_valid, busy});
      end
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL latency_early: got out_valid %b expected 0", out_valid);
      end
      @(negedge clk);
      n_cmp++;
      if ({out_valid, argmax} !== {1'b1, 3'd7}) begin
         n_fail++;
         $display("[TB] FAIL latency_out: got ov %b am %0d expected ov 1 am 7", out_valid, argmax);
      end
      wait_idle(ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL ramp_done: got 0 expected 1"); end
   endtask

   task automatic test_saturate();
      bit ok;
      frame_vals[0] = -32768;
      frame_vals[1] = 32767;
      for (int k = 2; k < 8; k++) frame_vals[k] = 0;
      send_frame(7);
      wait_idle(ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL saturate_done: got 0 expected 1"); end
   endtask

   task automatic test_ties();
      bit ok;
      int e0;
      e0 = err_cnt;
      for (int k = 0; k < 8; k++) frame_vals[k] = 100;
      send_frame(7);
      wait_idle(ok);
      n_cmp++;
      if ({ok, err_cnt - e0} !== {1'b1, 32'd0}) begin
         n_fail++;
         $display("[TB] FAIL ties_done: got ok %b errs %0d expected ok 1 errs 0", ok, err_cnt - e0);
      end
   endtask

   task automatic test_framing();
      bit ok;
      int r0;
      r0 = rd_cnt;
      for (int k = 0; k < 8; k++) frame_vals[k] = 10 * k - 30;
      send_frame(3);
      @(negedge clk);
      n_cmp++;
      if ({err_len, busy, in_ready} !== 3'b101) begin
         n_fail++;
         $display("[TB] FAIL short_frame: got err/busy/rdy %b expected 101", {err_len, busy, in_ready});
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({err_len, rd_cnt - r0} !== {1'b0, 32'd0}) begin
         n_fail++;
         $display("[TB] FAIL short_drop: got err %b reads %0d expected err 0 reads 0", err_len, rd_cnt - r0);
      end
      for (int k = 0; k < 8; k++) frame_vals[k] = 300 - 200 * k;
      send_frame(7);
      wait_idle(ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL framing_recover: got 0 expected 1"); end
   endtask

   task automatic test_no_last();
      bit ok;
      for (int k = 0; k < 8; k++) frame_vals[k] = (k == 5) ? 2000 : -1000 * k;
      send_frame(8);
      @(negedge clk);
      n_cmp++;
      if ({err_len, lut_rd_en} !== 2'b11) begin
         n_fail++;
         $display("[TB] FAIL missing_last: got err/rd %b expected 11", {err_len, lut_rd_en});
      end
      wait_idle(ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL missing_last_done: got 0 expected 1"); end
   endtask

   task automatic test_stall();
      bit ok;
      int r0, b0;
      r0 = rd_cnt;
      b0 = beat_cnt;
      for (int k = 0; k < 8; k++) frame_vals[k] = 37 * k * k - 500;
      rand_ready = 1'b1;
      send_frame(7);
      wait_idle(ok);
      rand_ready = 1'b0;
      n_cmp++;
      if ({ok, rd_cnt - r0, beat_cnt - b0} !== {1'b1, 32'd8, 32'd8}) begin
         n_fail++;
         $display("[TB] FAIL stall_counts: got ok %b reads %0d beats %0d expected ok 1 reads 8 beats 8",
                  ok, rd_cnt - r0, beat_cnt - b0);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int b0;
      logic signed [15:0] tmp;
      b0 = beat_cnt;
      for (int k = 0; k < 8; k++) frame_vals[k] = 1000 - 64 * k;
      send_frame(7);
      for (int k = 0; k < 8; k++) begin tmp = 16'($urandom); frame_vals[k] = tmp; end
      send_frame(7);
      wait_idle(ok);
      n_cmp++;
      if ({ok, beat_cnt - b0} !== {1'b1, 32'd16}) begin
         n_fail++;
         $display("[TB] FAIL b2b_counts: got ok %b beats %0d expected ok 1 beats 16", ok, beat_cnt - b0);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int k, g;
      for (int i = 0; i < 8; i++) frame_vals[i] = 128 * i - 400;
      send_frame(7);
      k = 0;
      g = 0;
      while (k < 5 && g < 500) begin @(negedge clk); g++; if (lut_rd_en) k++; end
      n_cmp++;
      if (k !== 5) begin n_fail++; $display("[TB] FAIL mid_reads: got %0d expected 5", k); end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({in_ready, lut_rd_en, out_valid, busy, err_len, out_data, argmax} !== 24'b0) begin
         n_fail++;
         $display("[TB] FAIL mid_reset: got %h expected 0",
                  {in_ready, lut_rd_en, out_valid, busy, err_len, out_data, argmax});
      end
      addr_q.delete();
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if ({in_ready, busy} !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL mid_release: got in_ready/busy %b expected 10", {in_ready, busy});
      end
      for (int i = 0; i < 8; i++) frame_vals[i] = (i == 2) ? 5000 : 4000 + 16 * i;
      send_frame(7);
      wait_idle(ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_new_frame: got 0 expected 1"); end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_saturate();
      test_ties();
      test_framing();
      test_no_last();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
